id_stage: RTL
=============

Name: id_stage

Overview:
- MIPS R2000 instruction-decode stage, directly downstream of the IF stage.
- Consumes the IF pipeline register (pc_in, inst_in) and holds the 32x32 register file, written from WB.
- Resolves branches and jumps in ID and drives br, pc_branch and except back to IF.
- Detects load-use and branch-operand hazards, drives hold_pc/hold_if, and produces the ID/EX pipeline register.

Parameters:
- EXC_VECTOR, 32'h8000_0180: exception vector, for documentation and bench use only; IF applies the vector.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_in  in  32  PC+4 of the instruction in ID
- inst_in  in  32  instruction word in ID (0 = NOP)
- hold_id  in  1  downstream stall; freezes ID/EX
- wb_we  in  1  WB register write enable
- wb_reg  in  5  WB destination register
- wb_data  in  32  WB write data
- mem_is_load  in  1  instruction in MEM is LW
- mem_dst  in  5  destination register of the instruction in MEM
- hold_pc  out  1  stall PC register
- hold_if  out  1  stall IF/ID register
- br  out  1  redirect fetch to pc_branch
- pc_branch  out  32  redirect target
- except  out  1  illegal instruction in ID
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc  out  32
- ex_rs_val  out  32
- ex_rt_val  out  32
- ex_imm  out  32  extended immediate
- ex_rs  out  5
- ex_rt  out  5
- ex_dst  out  5
- ex_alu_op  out  4
- ex_alu_src  out  1  1 = use imm
- ex_mem_read  out  1
- ex_mem_write  out  1
- ex_reg_we  out  1

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ex_* outputs and all 32 registers clear to 0.
  - hold_pc, hold_if, br and except are forced to 0 while rst_n is low.
- Register file:
  - Write at posedge when wb_we=1 and wb_reg!=0.
  - $0 always reads 0.
  - Combinational read on rs=inst_in[25:21] and rt=inst_in[20:16].
- Supported decode:
  - R-type funct: ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLL 00, SRL 02.
  - Opcodes: ADDI 08, ADDIU 09, SLTI 0A, ANDI 0C, ORI 0D, XORI 0E, LUI 0F, LW 23, SW 2B, BEQ 04, BNE 05, J 02.
- ALU op encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8, LUI=9.
- Immediate extension:
  - ANDI, ORI and XORI zero-extend the immediate.
  - All other immediates sign-extend.
  - For shifts, ex_imm = shamt zero-extended.
- Destination register:
  - R-type: dst = rd.
  - I-type: dst = rt.
  - ex_reg_we=0 whenever dst=0, so the all-zero word is a NOP.
- Illegal instruction (any unsupported opcode/funct):
  - except=1 combinationally.
  - A bubble enters ID/EX.
  - No register-file side effects.
- Branches and jumps:
  - BEQ/BNE taken: br=1, pc_branch = pc_in + {simm[29:0],2'b00}.
  - J: br=1, pc_branch = {pc_in[31:28], inst_in[25:0], 2'b00}.
  - A branch or jump writes a bubble into ID/EX.
  - A not-taken branch also writes a bubble.
- Hazard, stall = 1 when any of the following holds:
  - (a) load-use: ex_mem_read and ex_rt!=0 and ex_rt matches rs or rt used by the ID instruction.
  - (b) branch operand in EX: the ID instruction is BEQ/BNE, ex_reg_we=1, ex_dst!=0 and ex_dst matches rs or rt.
  - (c) branch operand in MEM: the ID instruction is BEQ/BNE, mem_is_load=1, mem_dst!=0 and mem_dst matches rs or rt.
- Outputs during stall:
  - hold_pc = hold_if = stall | hold_id.
  - br and except are suppressed while stall or hold_id is 1.
- ID/EX update at posedge:
  - hold_id=1: ID/EX holds its value.
  - Else, stall, br or except is 1: bubble (all ex_* = 0).
  - Else: load the decoded instruction with ex_valid=1.
- Priority: reset > hold_id > stall > except > br > normal.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined:
  - A register read returns wb_data when wb_we=1, wb_reg!=0 and wb_reg equals the read index (same-cycle write-through).
- Undefined:
  - Reads return the stored value.
  - Additional stall condition (d): wb_we=1, wb_reg!=0 and wb_reg matches rs or rt of the ID instruction.

Test Plan:
- Reset mid-run with rst_n=0 -> all ex_* = 0, hold_pc=hold_if=br=except=0; after release, inst_in=0 gives ex_valid=1, ex_reg_we=0.
- WB writes $5=32'h0000_1234, then ID sees ADDI $6,$5,-1 -> ex_rs_val=32'h1234, ex_imm=32'hFFFF_FFFF, ex_alu_op=0, ex_alu_src=1, ex_dst=6, ex_reg_we=1.
- LW $2,0($1) in EX, ID sees ADD $3,$2,$4 -> hold_pc=hold_if=1 for one cycle, bubble in ID/EX, ADD issues the following cycle.
- ID sees BEQ $1,$1,+3 with pc_in=32'h0000_0010 -> br=1, pc_branch=32'h0000_001C, bubble in ID/EX.
- ID sees J 0x0000040 with pc_in=32'h0000_0020 -> br=1, pc_branch=32'h0000_0100; ID sees opcode 3F -> except=1, bubble.
- hold_id=1 while ADD is decoded -> ID/EX unchanged and hold_pc=1; with ID_WB_BYPASS_EN, same-cycle WB of $5 gives ex_rs_val=wb_data, without it one extra stall cycle.

Source files
------------

// File: rtl/id_stage.sv
// MIPS R2000 decode stage: register file, branch/jump resolution, hazard stalls, ID/EX register.
// Optional ID_WB_BYPASS_EN: same-cycle WB write-through on reads instead of stalling on a pending write.
module id_stage #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        hold_id,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        mem_is_load,
  input  logic [4:0]  mem_dst,
  output logic        hold_pc,
  output logic        hold_if,
  output logic        br,
  output logic [31:0] pc_branch,
  output logic        except,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dst,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_we
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned AW   = 4;
  localparam int unsigned NREG = 32;

  typedef enum logic [AW-1:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_LUI = 4'd9
  } alu_op_e;

  logic [XLEN-1:0] r_regs [NREG];

  logic [5:0]      w_op, w_funct;
  logic [RW-1:0]   w_rs, w_rt, w_rd, w_shamt, w_dst;
  logic [15:0]     w_imm16;
  logic [XLEN-1:0] w_simm, w_imm, w_rs_val, w_rt_val;
  alu_op_e         w_alu_op;
  logic w_legal, w_rtype, w_zext, w_shift, w_alu_src, w_mem_read, w_mem_write, w_writes;
  logic w_use_rs, w_use_rt, w_is_beq, w_is_bne, w_is_j, w_taken, w_branch;
  logic w_load_use, w_br_ex, w_br_mem, w_stall_wb, w_stall, w_block, w_bubble;
  logic w_unused;

  assign w_op    = inst_in[31:26];
  assign w_rs    = inst_in[25:21];
  assign w_rt    = inst_in[20:16];
  assign w_rd    = inst_in[15:11];
  assign w_shamt = inst_in[10:6];
  assign w_funct = inst_in[5:0];
  assign w_imm16 = inst_in[15:0];
  assign w_unused = ^EXC_VECTOR;

  // Instruction decode
  always_comb begin
    w_legal = 1'b0; w_rtype = 1'b0; w_zext = 1'b0; w_shift = 1'b0;
    w_alu_op = ALU_ADD; w_alu_src = 1'b0; w_mem_read = 1'b0; w_mem_write = 1'b0;
    w_writes = 1'b0; w_use_rs = 1'b0; w_use_rt = 1'b0;
    w_is_beq = 1'b0; w_is_bne = 1'b0; w_is_j = 1'b0;
    case (w_op)
      6'h00: begin
        w_rtype = 1'b1; w_legal = 1'b1; w_writes = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1;
        case (w_funct)
          6'h20, 6'h21: w_alu_op = ALU_ADD;
          6'h22, 6'h23: w_alu_op = ALU_SUB;
          6'h24:        w_alu_op = ALU_AND;
          6'h25:        w_alu_op = ALU_OR;
          6'h26:        w_alu_op = ALU_XOR;
          6'h27:        w_alu_op = ALU_NOR;
          6'h2A:        w_alu_op = ALU_SLT;
          6'h00: begin w_alu_op = ALU_SLL; w_shift = 1'b1; w_use_rs = 1'b0; end
          6'h02: begin w_alu_op = ALU_SRL; w_shift = 1'b1; w_use_rs = 1'b0; end
          default: begin
            w_legal = 1'b0; w_writes = 1'b0; w_use_rs = 1'b0; w_use_rt = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09: begin w_legal = 1'b1; w_alu_op = ALU_ADD; w_alu_src = 1'b1; w_writes = 1'b1; w_use_rs = 1'b1; end
      6'h0A: begin w_legal = 1'b1; w_alu_op = ALU_SLT; w_alu_src = 1'b1; w_writes = 1'b1; w_use_rs = 1'b1; end
      6'h0C: begin w_legal = 1'b1; w_alu_op = ALU_AND; w_alu_src = 1'b1; w_writes = 1'b1; w_use_rs = 1'b1; w_zext = 1'b1; end
      6'h0D: begin w_legal = 1'b1; w_alu_op = ALU_OR;  w_alu_src = 1'b1; w_writes = 1'b1; w_use_rs = 1'b1; w_zext = 1'b1; end
      6'h0E: begin w_legal = 1'b1; w_alu_op = ALU_XOR; w_alu_src = 1'b1; w_writes = 1'b1; w_use_rs = 1'b1; w_zext = 1'b1; end
      6'h0F: begin w_legal = 1'b1; w_alu_op = ALU_LUI; w_alu_src = 1'b1; w_writes = 1'b1; end
      6'h23: begin w_legal = 1'b1; w_alu_src = 1'b1; w_mem_read = 1'b1; w_writes = 1'b1; w_use_rs = 1'b1; end
      6'h2B: begin w_legal = 1'b1; w_alu_src = 1'b1; w_mem_write = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; end
      6'h04: begin w_legal = 1'b1; w_is_beq = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; end
      6'h05: begin w_legal = 1'b1; w_is_bne = 1'b1; w_use_rs = 1'b1; w_use_rt = 1'b1; end
      6'h02: begin w_legal = 1'b1; w_is_j = 1'b1; end
      default: ;
    endcase
  end

  assign w_simm = {{16{w_imm16[15]}}, w_imm16};
  assign w_imm  = w_shift ? XLEN'(w_shamt) : (w_zext ? XLEN'(w_imm16) : w_simm);
  assign w_dst  = w_rtype ? w_rd : w_rt;

  // Register read ports; $0 is never written so it always reads zero
`ifdef ID_WB_BYPASS_EN
  assign w_rs_val   = (wb_we && wb_reg != '0 && wb_reg == w_rs) ? wb_data : r_regs[w_rs];
  assign w_rt_val   = (wb_we && wb_reg != '0 && wb_reg == w_rt) ? wb_data : r_regs[w_rt];
  assign w_stall_wb = 1'b0;
`else
  assign w_rs_val   = r_regs[w_rs];
  assign w_rt_val   = r_regs[w_rt];
  assign w_stall_wb = wb_we && wb_reg != '0 &&
                      ((w_use_rs && wb_reg == w_rs) || (w_use_rt && wb_reg == w_rt));
`endif

  assign w_branch = w_is_beq | w_is_bne;
  assign w_taken  = (w_is_beq && w_rs_val == w_rt_val) || (w_is_bne && w_rs_val != w_rt_val) || w_is_j;
  assign pc_branch = w_is_j ? {pc_in[31:28], inst_in[25:0], 2'b00} : pc_in + {w_simm[29:0], 2'b00};

  // Hazards: load-use, and branch operands still in flight in EX or MEM
  assign w_load_use = ex_mem_read && ex_rt != '0 &&
                      ((w_use_rs && ex_rt == w_rs) || (w_use_rt && ex_rt == w_rt));
  assign w_br_ex    = w_branch && ex_reg_we && ex_dst != '0 && (ex_dst == w_rs || ex_dst == w_rt);
  assign w_br_mem   = w_branch && mem_is_load && mem_dst != '0 && (mem_dst == w_rs || mem_dst == w_rt);
  assign w_stall    = w_load_use | w_br_ex | w_br_mem | w_stall_wb;
  assign w_block    = w_stall | hold_id;
  assign w_bubble   = w_stall | ~w_legal | w_branch | w_is_j;

  assign hold_pc = rst_n & w_block;
  assign hold_if = rst_n & w_block;
  assign br      = rst_n & ~w_block & w_taken;
  assign except  = rst_n & ~w_block & ~w_legal;

  // Register file write from WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) r_regs[i] <= '0;
    end else if (wb_we && wb_reg != '0) begin
      r_regs[wb_reg] <= wb_data;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0; ex_pc <= '0; ex_rs_val <= '0; ex_rt_val <= '0; ex_imm <= '0;
      ex_rs <= '0; ex_rt <= '0; ex_dst <= '0; ex_alu_op <= '0; ex_alu_src <= 1'b0;
      ex_mem_read <= 1'b0; ex_mem_write <= 1'b0; ex_reg_we <= 1'b0;
    end else if (hold_id) begin
      ex_valid <= ex_valid;
    end else if (w_bubble) begin
      ex_valid <= 1'b0; ex_pc <= '0; ex_rs_val <= '0; ex_rt_val <= '0; ex_imm <= '0;
      ex_rs <= '0; ex_rt <= '0; ex_dst <= '0; ex_alu_op <= '0; ex_alu_src <= 1'b0;
      ex_mem_read <= 1'b0; ex_mem_write <= 1'b0; ex_reg_we <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ex_pc        <= pc_in;
      ex_rs_val    <= w_rs_val;
      ex_rt_val    <= w_rt_val;
      ex_imm       <= w_imm;
      ex_rs        <= w_rs;
      ex_rt        <= w_rt;
      ex_dst       <= w_dst;
      ex_alu_op    <= w_alu_op;
      ex_alu_src   <= w_alu_src;
      ex_mem_read  <= w_mem_read;
      ex_mem_write <= w_mem_write;
      ex_reg_we    <= w_writes && w_dst != '0;
    end
  end
endmodule
